ram_bank: RTL and testbench

Parametrised synchronous single-port RAM bank. It is the successor to the fixed 32x32 bidirectional-bus RAM.
- Splits the data bus into separate din/dout.
- Adds per-byte write enables, a registered read with a valid strobe, and a selectable read-during-write mode.
- Adds a built-in clear sequencer that zeroes the array after reset or on request.
- Used as the generic storage block behind register files and scratch memories in the lab designs.

---
 rtl/ram_bank.sv | 149 ++++++++++++++
 tb/tb_ram_bank.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bank.sv
// rtl/ram_bank.sv - parametrised single-port RAM bank with byte enables and clear sequencer
//
// Purpose:
//   Synchronous single-port RAM with separate data in/out buses, per-byte
//   write enables, a registered read with a one-cycle valid strobe, a
//   selectable read-during-write result and a sequencer that zeroes the
//   whole array after reset or on request.
//
// Ports:
//   i_clk        system clock, all state on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_ena        access enable, ignored while o_busy=1
//   i_wena       1 = write, 0 = read (qualified by i_ena)
//   i_be         byte write enables, bit i covers i_din[8i+7:8i]
//   i_addr       word address
//   i_din        write data
//   i_clr        clear request, sampled in IDLE only
//   o_dout       registered read data
//   o_dout_valid one-cycle strobe, o_dout updated by the previous access
//   o_busy       clear sequence in progress, accesses rejected

module ram_bank #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_ena,
    input  logic                      i_wena,
    input  logic [DATA_WIDTH/8-1:0]   i_be,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    input  logic [DATA_WIDTH-1:0]     i_din,
    input  logic                      i_clr,
    output logic [DATA_WIDTH-1:0]     o_dout,
    output logic                      o_dout_valid,
    output logic                      o_busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [0:0]            RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_valid;

    logic                  w_idle;
    logic                  w_access;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;

    assign w_idle = (r_state == ST_IDLE);
    // clr wins over a same-cycle access: that access is dropped entirely
    assign w_access = w_idle && i_ena && !i_clr;
    assign w_old = r_mem[i_addr];

    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < NBYTES; i++) begin
            if (i_be[i]) begin
                w_merged[8*i +: 8] = i_din[8*i +: 8];
            end
        end
    end

    // Single array write port shared between the clear sequencer and user writes
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = i_addr;
        w_mem_wdata = w_merged;
        if (r_state == ST_CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_ptr;
            w_mem_wdata = '0;
        end else if (w_access && i_wena) begin
            w_mem_we = 1'b1;
        end
    end

    // Array has no reset; only the clear sequencer initialises it
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RESET_STATE;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_clr) begin
                        r_state <= ST_CLEAR;
                        r_ptr   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (r_ptr == LAST_ADDR) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_access;
            if (w_access) begin
                // Read-during-write: old word (read-first) or merged word (write-first)
                if (i_wena && (RDW_MODE != 0)) begin
                    r_dout <= w_merged;
                end else begin
                    r_dout <= w_old;
                end
            end
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_busy       = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_ram_bank.sv
// tb/tb_ram_bank.sv - directed self-checking bench for ram_bank

module tb_ram_bank;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        wena;
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] din;
    logic        clr;

    logic [31:0] dout0, dout1, dout2;
    logic        valid0, valid1, valid2;
    logic        busy0, busy1, busy2;

    int checks;
    int failures;

    ram_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_wena(wena), .i_be(be),
        .i_addr(addr), .i_din(din), .i_clr(clr),
        .o_dout(dout0), .o_dout_valid(valid0), .o_busy(busy0)
    );

    ram_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_wena(wena), .i_be(be),
        .i_addr(addr), .i_din(din), .i_clr(clr),
        .o_dout(dout1), .o_dout_valid(valid1), .o_busy(busy1)
    );

    ram_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .RDW_MODE(0), .CLEAR_ON_RESET(0)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_wena(wena), .i_be(be),
        .i_addr(addr), .i_din(din), .i_clr(clr),
        .o_dout(dout2), .o_dout_valid(valid2), .o_busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        ena  = 1'b1;
        wena = w;
        addr = a;
        din  = d;
        be   = b;
        step();
        ena  = 1'b0;
        wena = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena = 1'b0; wena = 1'b0; be = 4'h0; addr = '0; din = '0; clr = 1'b0;
        step();
        step();
        checks++;
        if (dout0 !== 32'h0 || valid0 !== 1'b0 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL reset_state dut0: dout=%h valid=%b busy=%b required dout=0 valid=0 busy=1", dout0, valid0, busy0);
        end
        checks++;
        if (busy2 !== 1'b0 || valid2 !== 1'b0 || dout2 !== 32'h0) begin
            failures++;
            $display("FAIL reset_state_noclear: dout=%h valid=%b busy=%b required dout=0 valid=0 busy=0", dout2, valid2, busy2);
        end
    endtask

    task automatic count_busy(input string name);
        int cnt;
        cnt = 0;
        while (busy0 === 1'b1 && cnt < 100) begin
            cnt++;
            step();
        end
        checks++;
        if (cnt != 32 || busy1 !== 1'b0) begin
            failures++;
            $display("FAIL %s: busy cycles=%0d busy1=%b required 32 and 0", name, cnt, busy1);
        end
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < 32; i++) begin
            access(1'b0, 5'(i), 32'h0, 4'h0);
            checks++;
            if (dout0 !== 32'h0 || valid0 !== 1'b1 || dout1 !== 32'h0 || valid1 !== 1'b1) begin
                failures++;
                $display("FAIL %s addr=%0d: dout0=%h v0=%b dout1=%h v1=%b required 0 and valid", name, i, dout0, valid0, dout1, valid1);
            end
        end
    endtask

    task automatic test_clear_after_reset();
        rst_n = 1'b1;
        count_busy("clear_after_reset_busy");
        read_all_zero("clear_after_reset_read");
        step();
        checks++;
        if (valid0 !== 1'b0 || dout0 !== 32'h0) begin
            failures++;
            $display("FAIL idle_hold: valid=%b dout=%h required valid=0 dout=0", valid0, dout0);
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 32; i++) begin
            access(1'b1, 5'(i), 32'(5 * i), 4'hF);
            checks++;
            if (dout0 !== 32'h0 || dout1 !== 32'(5 * i) || valid0 !== 1'b1) begin
                failures++;
                $display("FAIL write_rdw addr=%0d: dout0=%h dout1=%h v=%b required %h %h 1", i, dout0, dout1, valid0, 32'h0, 32'(5 * i));
            end
        end
        for (int i = 0; i < 32; i++) begin
            access(1'b0, 5'(i), 32'h0, 4'h0);
            checks++;
            if (dout0 !== 32'(5 * i) || valid0 !== 1'b1 || dout1 !== 32'(5 * i)) begin
                failures++;
                $display("FAIL read_back addr=%0d: dout0=%h dout1=%h v=%b required %h", i, dout0, dout1, valid0, 32'(5 * i));
            end
        end
    endtask

    task automatic test_byte_enable();
        access(1'b1, 5'd10, 32'hFFFF0000, 4'b1100);
        checks++;
        if (dout0 !== 32'h00000032 || dout1 !== 32'hFFFF0032) begin
            failures++;
            $display("FAIL byte_en_write: dout0=%h dout1=%h required 00000032 FFFF0032", dout0, dout1);
        end
        access(1'b0, 5'd10, 32'h0, 4'h0);
        checks++;
        if (dout0 !== 32'hFFFF0032 || dout1 !== 32'hFFFF0032) begin
            failures++;
            $display("FAIL byte_en_read: dout0=%h dout1=%h required FFFF0032", dout0, dout1);
        end
        access(1'b1, 5'd4, 32'hFFFFFFFF, 4'b0000);
        checks++;
        if (dout0 !== 32'd20 || dout1 !== 32'd20 || valid0 !== 1'b1) begin
            failures++;
            $display("FAIL be_zero_write: dout0=%h dout1=%h v=%b required 00000014", dout0, dout1, valid0);
        end
        access(1'b0, 5'd4, 32'h0, 4'h0);
        checks++;
        if (dout0 !== 32'd20) begin
            failures++;
            $display("FAIL be_zero_read: dout=%h required 00000014", dout0);
        end
    endtask

    task automatic test_rdw_mode();
        access(1'b1, 5'd3, 32'hA5A5A5A5, 4'hF);
        checks++;
        if (dout0 !== 32'h0000000F) begin
            failures++;
            $display("FAIL rdw_read_first: dout=%h required 0000000F", dout0);
        end
        checks++;
        if (dout1 !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL rdw_write_first: dout=%h required A5A5A5A5", dout1);
        end
        access(1'b0, 5'd3, 32'h0, 4'h0);
        checks++;
        if (dout0 !== 32'hA5A5A5A5 || dout1 !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL rdw_followup_read: dout0=%h dout1=%h required A5A5A5A5", dout0, dout1);
        end
    endtask

    task automatic test_back_to_back();
        ena = 1'b1; wena = 1'b1; addr = 5'd5; din = 32'hDEADBEEF; be = 4'hF;
        step();
        wena = 1'b0; din = 32'h0;
        step();
        ena = 1'b0;
        checks++;
        if (dout0 !== 32'hDEADBEEF || valid0 !== 1'b1 || dout1 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL back_to_back: dout0=%h dout1=%h v=%b required DEADBEEF", dout0, dout1, valid0);
        end
    endtask

    task automatic test_clr();
        int cnt;
        ena = 1'b1; wena = 1'b1; addr = 5'd7; din = 32'h12345678; be = 4'hF; clr = 1'b1;
        step();
        clr = 1'b0; wena = 1'b0; addr = 5'd3;
        cnt = 0;
        while (busy0 === 1'b1 && cnt < 100) begin
            checks++;
            if (valid0 !== 1'b0 || dout0 !== 32'hDEADBEEF || valid1 !== 1'b0) begin
                failures++;
                $display("FAIL clr_busy_access cyc=%0d: v0=%b v1=%b dout=%h required 0 0 DEADBEEF", cnt, valid0, valid1, dout0);
            end
            ena = cnt[0];
            clr = (cnt == 5);
            cnt++;
            step();
        end
        ena = 1'b0; clr = 1'b0;
        checks++;
        if (cnt != 32) begin
            failures++;
            $display("FAIL clr_busy_len: busy cycles=%0d required 32", cnt);
        end
        access(1'b0, 5'd7, 32'h0, 4'h0);
        checks++;
        if (dout0 !== 32'h0 || valid0 !== 1'b1 || dout1 !== 32'h0) begin
            failures++;
            $display("FAIL clr_dropped_write: dout0=%h dout1=%h v=%b required 0", dout0, dout1, valid0);
        end
    endtask

    task automatic test_reset_mid_clear();
        access(1'b1, 5'd9, 32'h13579BDF, 4'hF);
        access(1'b0, 5'd9, 32'h0, 4'h0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout0 !== 32'h0 || valid0 !== 1'b0 || dout1 !== 32'h0 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_clear: dout0=%h dout1=%h v=%b busy=%b required 0 0 0 1", dout0, dout1, valid0, busy0);
        end
        step();
        step();
        rst_n = 1'b1;
        checks++;
        if (busy2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_noclear_idle: busy=%b required 0", busy2);
        end
        count_busy("reset_mid_clear_busy");
        read_all_zero("reset_mid_clear_read");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_clear_after_reset();
        test_write_read();
        test_byte_enable();
        test_rdw_mode();
        test_back_to_back();
        test_clr();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
